floating_point_rounder: RTL and testbench

- Final rounding stage for the FPU. It consumes the unrounded result, the guard/round/sticky bits and the exception flags produced by upstream units such as the converter, adder and multiplier.
- It applies the RISC-V rounding mode and outputs the rounded float32 or 32-bit integer with final exception flags.
- It is a two-stage pipeline that accepts one operation per cycle and stalls on clock enable.

---
 rtl/floating_point_rounder.sv | 222 ++++++++++++++++++++++
 tb/tb_floating_point_rounder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_rounder.sv
// Purpose: final FPU rounding stage. Applies the RISC-V rounding mode to an
//          unrounded float32 or int32 value and produces the final exception flags.
// Latency: 2 enabled cycles. No backpressure; clk_en_i=0 freezes every stage register.
// Ports:
//   clk_i, rst_i (sync, active-high), clk_en_i (pipeline advance)
//   valid_i, operand_i, round_bits_i {G,R,S}, round_enable_i, is_integer_i,
//   signed_i, int_sign_i, rounding_mode_i, inexact_i/overflow_i/underflow_i
//   valid_o, result_o, inexact_o/overflow_o/underflow_o, illegal_rm_o
module floating_point_rounder #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [2:0]       round_bits_i,
  input  logic             round_enable_i,
  input  logic             is_integer_i,
  input  logic             signed_i,
  input  logic             int_sign_i,
  input  logic [2:0]       rounding_mode_i,
  input  logic             inexact_i,
  input  logic             overflow_i,
  input  logic             underflow_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             inexact_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             illegal_rm_o
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // How stage 2 builds the result:
  //   NONE - apply the increment (normal rounding)
  //   PASS - operand goes out untouched (rounding off, inf/NaN, int pre-saturated)
  //   FSAT - float overflowed upstream; pick inf or max-finite from the mode
  typedef enum logic [1:0] {
    BYP_NONE = 2'd0,
    BYP_PASS = 2'd1,
    BYP_FSAT = 2'd2
  } byp_e;

  // ---------------------------------------------------------------------------
  // Stage 1: increment decision
  // ---------------------------------------------------------------------------
  logic       g, r, st, grs_any;
  logic       sign1;
  logic       float_special;
  logic       rm_illegal;
  logic [2:0] rm_eff;
  logic       inc_raw;
  logic       inc1;
  logic       inexact1;
  byp_e       byp1;

  assign g             = round_bits_i[2];
  assign r             = round_bits_i[1];
  assign st            = round_bits_i[0];
  assign grs_any       = |round_bits_i;
  assign sign1         = is_integer_i ? int_sign_i : operand_i[31];
  assign float_special = !is_integer_i && (operand_i[30:23] == 8'hFF);
  assign rm_illegal    = (rounding_mode_i > RM_RMM);
  // Reserved modes round as RNE; illegal_rm_o tells software it happened.
  assign rm_eff        = rm_illegal ? RM_RNE : rounding_mode_i;

  always_comb begin
    inc_raw = 1'b0;
    case (rm_eff)
      RM_RTZ:  inc_raw = 1'b0;
      RM_RDN:  inc_raw = sign1 & grs_any;
      RM_RUP:  inc_raw = ~sign1 & grs_any;
      RM_RMM:  inc_raw = g;
      default: inc_raw = g & (r | st | operand_i[0]);
    endcase
  end

  always_comb begin
    byp1 = BYP_NONE;
    if (!round_enable_i) begin
      byp1 = BYP_PASS;
    end else if (is_integer_i) begin
      if (overflow_i || underflow_i) byp1 = BYP_PASS;
    end else if (float_special) begin
      byp1 = BYP_PASS;
    end else if (overflow_i) begin
      byp1 = BYP_FSAT;
    end
  end

  assign inc1     = round_enable_i && (byp1 == BYP_NONE) && inc_raw;
  // inf/NaN are exact, so discarded round bits do not make them inexact.
  assign inexact1 = inexact_i | (round_enable_i & ~float_special & grs_any);

  logic        s1_vld;
  logic [31:0] s1_op;
  logic        s1_inc;
  logic        s1_sign;
  logic        s1_is_int;
  logic        s1_signed;
  logic [2:0]  s1_rm;
  logic        s1_ill;
  logic        s1_inx;
  logic        s1_ovf;
  logic        s1_unf;
  byp_e        s1_byp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0;
    end else if (clk_en_i) begin
      s1_vld <= valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clk_en_i) begin
      s1_op     <= operand_i;
      s1_inc    <= inc1;
      s1_sign   <= sign1;
      s1_is_int <= is_integer_i;
      s1_signed <= signed_i;
      s1_rm     <= rm_eff;
      s1_ill    <= rm_illegal;
      s1_inx    <= inexact1;
      s1_ovf    <= overflow_i;
      s1_unf    <= underflow_i;
      s1_byp    <= byp1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: apply increment, saturate, merge flags
  // ---------------------------------------------------------------------------
  logic [32:0] m;
  logic [30:0] f_sum;
  logic [31:0] f_inf, f_max;
  logic [31:0] res_d;
  logic        inx_d, ovf_d, unf_d;

  // One extra bit so an all-ones magnitude plus one is still visible.
  assign m     = {1'b0, s1_op} + {32'd0, s1_inc};
  // Carry out of the significand ripples straight into the exponent field.
  assign f_sum = s1_op[30:0] + {30'd0, s1_inc};
  assign f_inf = {s1_sign, 8'hFF, 23'd0};
  assign f_max = {s1_sign, 8'hFE, 23'h7FFFFF};

  always_comb begin
    res_d = s1_op;
    inx_d = s1_inx;
    ovf_d = s1_ovf;
    unf_d = s1_unf;
    case (s1_byp)
      BYP_FSAT: begin
        case (s1_rm)
          RM_RTZ:  res_d = f_max;
          RM_RDN:  res_d = s1_sign ? f_inf : f_max;
          RM_RUP:  res_d = s1_sign ? f_max : f_inf;
          default: res_d = f_inf;
        endcase
      end
      BYP_NONE: begin
        if (s1_is_int) begin
          if (s1_signed) begin
            if (!s1_sign && (m > 33'h07FFFFFFF)) begin
              res_d = 32'h7FFFFFFF;
              ovf_d = 1'b1;
            end else if (s1_sign && (m > 33'h080000000)) begin
              res_d = 32'h80000000;
              unf_d = 1'b1;
            end else begin
              res_d = s1_sign ? (~m[31:0] + 32'd1) : m[31:0];
            end
          end else begin
            if (m[32]) begin
              res_d = 32'hFFFFFFFF;
              ovf_d = 1'b1;
            end else if (s1_sign) begin
              // Negative values clamp to zero; exactly -0 is not an underflow.
              res_d = 32'd0;
              if (m != 33'd0) unf_d = 1'b1;
            end else begin
              res_d = m[31:0];
            end
          end
        end else if (f_sum[30:23] == 8'hFF) begin
          res_d = f_inf;
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          res_d = {s1_sign, f_sum};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      result_o     <= '0;
      inexact_o    <= 1'b0;
      overflow_o   <= 1'b0;
      underflow_o  <= 1'b0;
      illegal_rm_o <= 1'b0;
    end else if (clk_en_i) begin
      valid_o      <= s1_vld;
      result_o     <= res_d;
      inexact_o    <= inx_d;
      overflow_o   <= ovf_d;
      underflow_o  <= unf_d;
      illegal_rm_o <= s1_ill;
    end
  end

endmodule

// File: tb/tb_floating_point_rounder.sv
// Bench for floating_point_rounder: scoreboard of expected results pushed at
// drive time and popped when valid_o is seen after an enabled edge.
module tb_floating_point_rounder;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  typedef struct packed {
    logic [31:0] opnd;
    logic [2:0]  grs;
    logic [2:0]  rm;
    logic        isint;
    logic        sgn;
    logic        isign;
    logic        inx;
    logic        ovf;
    logic        unf;
    logic        ren;
  } op_t;

  // flg = {inexact, overflow, underflow, illegal_rm}
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i, clk_en_i, valid_i;
  logic [31:0] operand_i;
  logic [2:0]  round_bits_i, rounding_mode_i;
  logic        round_enable_i, is_integer_i, signed_i, int_sign_i;
  logic        inexact_i, overflow_i, underflow_i;
  logic [31:0] result_o;
  logic        valid_o, inexact_o, overflow_o, underflow_o, illegal_rm_o;
  logic [3:0]  flg_obs;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  assign flg_obs = {inexact_o, overflow_o, underflow_o, illegal_rm_o};

  always #5 clk_i = ~clk_i;

  floating_point_rounder #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .valid_i(valid_i),
    .operand_i(operand_i), .round_bits_i(round_bits_i),
    .round_enable_i(round_enable_i), .is_integer_i(is_integer_i),
    .signed_i(signed_i), .int_sign_i(int_sign_i),
    .rounding_mode_i(rounding_mode_i), .inexact_i(inexact_i),
    .overflow_i(overflow_i), .underflow_i(underflow_i),
    .result_o(result_o), .valid_o(valid_o), .inexact_o(inexact_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .illegal_rm_o(illegal_rm_o)
  );

  function automatic op_t mk(input logic [31:0] a, input logic [2:0] grs,
                             input logic [2:0] rm, input logic isint,
                             input logic sgn, input logic isign,
                             input logic inx, input logic ovf,
                             input logic unf, input logic ren);
    op_t o;
    o.opnd = a; o.grs = grs; o.rm = rm; o.isint = isint; o.sgn = sgn;
    o.isign = isign; o.inx = inx; o.ovf = ovf; o.unf = unf; o.ren = ren;
    return o;
  endfunction

  // Drive one cycle of inputs (called just after a negedge); an op that will
  // be sampled at the next posedge has its expected result queued.
  task automatic drive(input op_t o, input logic vld, input logic en, input exp_t e);
    clk_en_i        = en;
    valid_i         = vld;
    operand_i       = o.opnd;
    round_bits_i    = o.grs;
    rounding_mode_i = o.rm;
    is_integer_i    = o.isint;
    signed_i        = o.sgn;
    int_sign_i      = o.isign;
    inexact_i       = o.inx;
    overflow_i      = o.ovf;
    underflow_i     = o.unf;
    round_enable_i  = o.ren;
    if (vld && en && !rst_i) sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(mk(32'h0, 3'b000, RNE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1),
          1'b0, 1'b0, '{32'h0, 4'h0});
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid_o); end
    checks++;
    if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 00000000", result_o); end
    checks++;
    if (flg_obs !== 4'h0) begin errors++; $display("FAIL reset_flags got %b expected 0000", flg_obs); end
    rst_i = 1'b0;
    clk_en_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_float();
    op_t  ov[16];
    exp_t ev[16];
    exp_t e;
    ov[0]  = mk(32'h3F800000, 3'b100, RNE,    0, 0, 0, 0, 0, 0, 1); ev[0]  = '{32'h3F800000, 4'b1000};
    ov[1]  = mk(32'h3F800001, 3'b100, RNE,    0, 0, 0, 0, 0, 0, 1); ev[1]  = '{32'h3F800002, 4'b1000};
    ov[2]  = mk(32'h3FFFFFFF, 3'b100, RUP,    0, 0, 0, 0, 0, 0, 1); ev[2]  = '{32'h40000000, 4'b1000};
    ov[3]  = mk(32'h7F7FFFFF, 3'b100, RNE,    0, 0, 0, 0, 0, 0, 1); ev[3]  = '{32'h7F800000, 4'b1100};
    ov[4]  = mk(32'h7F7FFFFF, 3'b100, RTZ,    0, 0, 0, 0, 0, 0, 1); ev[4]  = '{32'h7F7FFFFF, 4'b1000};
    ov[5]  = mk(32'h7F7FFFFF, 3'b100, 3'b101, 0, 0, 0, 0, 0, 0, 1); ev[5]  = '{32'h7F800000, 4'b1101};
    ov[6]  = mk(32'hBF800001, 3'b001, RDN,    0, 0, 0, 0, 0, 0, 1); ev[6]  = '{32'hBF800002, 4'b1000};
    ov[7]  = mk(32'hBF800001, 3'b001, RUP,    0, 0, 0, 0, 0, 0, 1); ev[7]  = '{32'hBF800001, 4'b1000};
    ov[8]  = mk(32'h3F800000, 3'b100, RMM,    0, 0, 0, 0, 0, 0, 1); ev[8]  = '{32'h3F800001, 4'b1000};
    ov[9]  = mk(32'h7F800000, 3'b000, RUP,    0, 0, 0, 0, 0, 0, 1); ev[9]  = '{32'h7F800000, 4'b0000};
    ov[10] = mk(32'h7F7FFFFF, 3'b000, RTZ,    0, 0, 0, 1, 1, 0, 1); ev[10] = '{32'h7F7FFFFF, 4'b1100};
    ov[11] = mk(32'hFF7FFFFF, 3'b000, RDN,    0, 0, 0, 1, 1, 0, 1); ev[11] = '{32'hFF800000, 4'b1100};
    ov[12] = mk(32'hFF7FFFFF, 3'b000, RUP,    0, 0, 0, 1, 1, 0, 1); ev[12] = '{32'hFF7FFFFF, 4'b1100};
    ov[13] = mk(32'h7F7FFFFF, 3'b000, RNE,    0, 0, 0, 1, 1, 0, 1); ev[13] = '{32'h7F800000, 4'b1100};
    ov[14] = mk(32'h3F800000, 3'b000, RNE,    0, 0, 0, 0, 0, 0, 1); ev[14] = '{32'h3F800000, 4'b0000};
    ov[15] = mk(32'h3F800000, 3'b110, RNE,    0, 0, 0, 0, 0, 0, 1); ev[15] = '{32'h3F800001, 4'b1000};
    for (int i = 0; i < 19; i++) begin
      if (i < 16) drive(ov[i], 1'b1, 1'b1, ev[i]);
      else        drive(ov[0], 1'b0, 1'b1, ev[0]);
      @(negedge clk_i);
      if (clk_en_i && valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL float_extra unexpected valid_o result %h", result_o);
        end else begin
          e = sb.pop_front();
          if (result_o !== e.res) begin errors++; $display("FAIL float_result got %h expected %h", result_o, e.res); end
          checks++;
          if (flg_obs !== e.flg) begin errors++; $display("FAIL float_flags for %h got %b expected %b", e.res, flg_obs, e.flg); end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL float_lost %0d results missing expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_integer();
    op_t  ov[12];
    exp_t ev[12];
    exp_t e;
    ov[0]  = mk(32'h7FFFFFFF, 3'b100, RUP,    1, 1, 0, 0, 0, 0, 1); ev[0]  = '{32'h7FFFFFFF, 4'b1100};
    ov[1]  = mk(32'h00000005, 3'b001, RDN,    1, 1, 1, 0, 0, 0, 1); ev[1]  = '{32'hFFFFFFFA, 4'b1000};
    ov[2]  = mk(32'hFFFFFFFF, 3'b110, RNE,    1, 0, 0, 0, 0, 0, 1); ev[2]  = '{32'hFFFFFFFF, 4'b1100};
    ov[3]  = mk(32'h00000000, 3'b001, RDN,    1, 0, 1, 0, 0, 0, 1); ev[3]  = '{32'h00000000, 4'b1010};
    ov[4]  = mk(32'h7FFFFFFF, 3'b001, RDN,    1, 1, 1, 0, 0, 0, 1); ev[4]  = '{32'h80000000, 4'b1000};
    ov[5]  = mk(32'h80000000, 3'b001, RDN,    1, 1, 1, 0, 0, 0, 1); ev[5]  = '{32'h80000000, 4'b1010};
    ov[6]  = mk(32'h00000000, 3'b001, RUP,    1, 0, 1, 0, 0, 0, 1); ev[6]  = '{32'h00000000, 4'b1000};
    ov[7]  = mk(32'h00000002, 3'b100, RNE,    1, 1, 0, 0, 0, 0, 1); ev[7]  = '{32'h00000002, 4'b1000};
    ov[8]  = mk(32'h00000003, 3'b100, RNE,    1, 1, 0, 0, 0, 0, 1); ev[8]  = '{32'h00000004, 4'b1000};
    ov[9]  = mk(32'h7FFFFFFF, 3'b100, RUP,    1, 1, 0, 0, 1, 0, 1); ev[9]  = '{32'h7FFFFFFF, 4'b1100};
    ov[10] = mk(32'h00000009, 3'b010, RTZ,    1, 1, 1, 0, 0, 0, 1); ev[10] = '{32'hFFFFFFF7, 4'b1000};
    ov[11] = mk(32'h00000006, 3'b011, 3'b111, 1, 0, 0, 0, 0, 0, 1); ev[11] = '{32'h00000006, 4'b1001};
    for (int i = 0; i < 15; i++) begin
      if (i < 12) drive(ov[i], 1'b1, 1'b1, ev[i]);
      else        drive(ov[0], 1'b0, 1'b1, ev[0]);
      @(negedge clk_i);
      if (clk_en_i && valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL int_extra unexpected valid_o result %h", result_o);
        end else begin
          e = sb.pop_front();
          if (result_o !== e.res) begin errors++; $display("FAIL int_result got %h expected %h", result_o, e.res); end
          checks++;
          if (flg_obs !== e.flg) begin errors++; $display("FAIL int_flags for %h got %b expected %b", e.res, flg_obs, e.flg); end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL int_lost %0d results missing expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_round_disable();
    op_t  ov[3];
    exp_t ev[3];
    exp_t e;
    ov[0] = mk(32'h12345678, 3'b100, RNE, 0, 0, 0, 0, 0, 0, 0); ev[0] = '{32'h12345678, 4'b0000};
    ov[1] = mk(32'h12345678, 3'b100, RUP, 0, 0, 0, 1, 1, 0, 0); ev[1] = '{32'h12345678, 4'b1100};
    ov[2] = mk(32'h7F7FFFFF, 3'b111, RUP, 1, 1, 0, 0, 0, 1, 0); ev[2] = '{32'h7F7FFFFF, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(ov[i], 1'b1, 1'b1, ev[i]);
      else       drive(ov[0], 1'b0, 1'b1, ev[0]);
      @(negedge clk_i);
      if (clk_en_i && valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL noround_extra unexpected valid_o result %h", result_o);
        end else begin
          e = sb.pop_front();
          if (result_o !== e.res) begin errors++; $display("FAIL noround_result got %h expected %h", result_o, e.res); end
          checks++;
          if (flg_obs !== e.flg) begin errors++; $display("FAIL noround_flags got %b expected %b", flg_obs, e.flg); end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL noround_lost %0d results missing expected 0", sb.size()); sb.delete(); end
  endtask

  // Six back-to-back ops with a 3-cycle stall after the third; during the
  // stall valid_i stays high with a junk op that must never be sampled.
  task automatic test_back_to_back();
    op_t  bv[6];
    exp_t be[6];
    op_t  junk;
    exp_t e;
    logic [36:0] prev;
    int nxt = 0;
    junk = mk(32'h0000DEAD, 3'b000, RNE, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      bv[i] = mk(32'd10 + 32'(i), 3'b001, RUP, 1, 0, 0, 0, 0, 0, 1);
      be[i] = '{32'd11 + 32'(i), 4'b1000};
    end
    prev = {valid_o, result_o, flg_obs};
    for (int k = 0; k < 14; k++) begin
      if (k >= 3 && k < 6) drive(junk, 1'b1, 1'b0, be[0]);
      else if (nxt < 6) begin drive(bv[nxt], 1'b1, 1'b1, be[nxt]); nxt++; end
      else drive(junk, 1'b0, 1'b1, be[0]);
      @(negedge clk_i);
      if (!clk_en_i) begin
        checks++;
        if ({valid_o, result_o, flg_obs} !== prev) begin
          errors++; $display("FAIL stall_hold got %h expected %h", {valid_o, result_o, flg_obs}, prev);
        end
      end else if (valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra unexpected valid_o result %h", result_o);
        end else begin
          e = sb.pop_front();
          if (result_o !== e.res) begin errors++; $display("FAIL b2b_result got %h expected %h", result_o, e.res); end
          checks++;
          if (flg_obs !== e.flg) begin errors++; $display("FAIL b2b_flags got %b expected %b", flg_obs, e.flg); end
        end
      end
      prev = {valid_o, result_o, flg_obs};
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_lost %0d results missing expected 0", sb.size()); sb.delete(); end
  endtask

  // Op A completes, op B is caught in stage 1 by a reset taken while stalled.
  task automatic test_reset_inflight();
    op_t a, b;
    a = mk(32'd100, 3'b000, RTZ, 1, 0, 0, 0, 0, 0, 1);
    b = mk(32'd200, 3'b000, RTZ, 1, 0, 0, 0, 0, 0, 1);
    drive(a, 1'b1, 1'b1, '{32'd100, 4'b0000});
    @(negedge clk_i);
    drive(b, 1'b1, 1'b1, '{32'd200, 4'b0000});
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b1 || result_o !== 32'd100) begin
      errors++; $display("FAIL inflight_first got valid %b result %h expected valid 1 result 00000064", valid_o, result_o);
    end
    sb.delete();
    rst_i = 1'b1;
    drive(a, 1'b0, 1'b0, '{32'd0, 4'b0000});
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || result_o !== 32'd0 || flg_obs !== 4'h0) begin
      errors++; $display("FAIL inflight_reset got valid %b result %h flags %b expected 0 00000000 0000", valid_o, result_o, flg_obs);
    end
    rst_i = 1'b0;
    clk_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL inflight_ghost cycle %0d got valid %b expected 0", i, valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_float();
    test_integer();
    test_round_disable();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
